// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Value held at the head when the buffer is empty, so outputs read as a NOP.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; head_o is a register that reads EMPTY_ENTRY when empty.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    if (flush_i) begin
      head_d  = EMPTY_ENTRY;
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (do_push) begin
            head_d  = wdata_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            head_d = wdata_i;
          end else if (do_push) begin
            tail_d  = wdata_i;
            count_d = 2'd2;
          end else if (do_pop) begin
            head_d  = EMPTY_ENTRY;
            count_d = 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            head_d = tail_q;
            if (do_push) tail_d = wdata_i;
            else         count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= EMPTY_ENTRY;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns fetch PC, issues one-outstanding imem requests
// under credit control and buffers responses in fetch_fifo.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic        R,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_if,
  output logic        valid_if
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head, fifo_wdata;
  logic         push, pop, grant;
  logic         out_after, can_issue, credit_ok;
  logic [2:0]   cnt_after;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    push       = (state_q == S_WAIT) && imem_rvalid && !R;
    pop        = EN && valid_if && !R;
    fifo_wdata = '{pc: pend_pc_q, instr: imem_rdata};
    cnt_after  = 3'(fifo_count) + 3'(push) - 3'(pop);
    // The in-flight request stops counting once its response lands this cycle.
    out_after  = (state_q != S_REQ) && !imem_rvalid;
    can_issue  = (state_q == S_REQ) || ((state_q == S_WAIT) && imem_rvalid);
    credit_ok  = (int'(cnt_after) + int'(out_after)) < FIFO_DEPTH;
    // Gating with rst_n keeps the request low throughout reset.
    imem_req   = rst_n && !R && can_issue && credit_ok;
    grant      = imem_req && imem_gnt;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    if (R) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_KILL;
        S_KILL:  state_d = imem_rvalid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ:   if (grant) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_d = grant ? S_WAIT : S_REQ;
        S_KILL:  if (imem_rvalid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pend_pc_d  = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (R),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_addr      = fetch_pc_q;
  assign PC_if          = fifo_head.pc;
  assign Instruction_if = fifo_head.instr;
  assign valid_if       = (fifo_count != 2'd0);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stimulus pushes expected consumed PCs,
// a monitor pops and checks every instruction handed downstream.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN, R;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_if, Instruction_if;
  logic        valid_if;

  logic        gnt_on   = 1'b1;
  logic        mem_auto = 1'b1;
  logic        man_rv   = 1'b0;
  logic [31:0] man_rd   = 32'h0;
  logic        auto_rv_q = 1'b0;
  logic [31:0] auto_rd_q = 32'h0;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .R(R), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_if(PC_if), .Instruction_if(Instruction_if), .valid_if(valid_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a + 32'h0010_0013;
  endfunction

  // Memory: grants when gnt_on, answers one cycle after a grant when mem_auto.
  assign imem_gnt    = gnt_on;
  assign imem_rvalid = auto_rv_q | man_rv;
  assign imem_rdata  = man_rv ? man_rd : auto_rd_q;
  always @(posedge clk) begin
    auto_rv_q <= imem_req && imem_gnt && mem_auto;
    auto_rd_q <= instr_of(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", PC_if, 32'h0);
    chk("rst_instr", Instruction_if, 32'h0000_0013);
    chk("rst_valid", {31'b0, valid_if}, 32'd0);
  endtask

  // Monitor: every instruction consumed downstream must match the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && valid_if && EN && !R) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pop: got pc %h expected none", PC_if);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", PC_if, e);
          chk("pop_instr", Instruction_if, instr_of(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; EN = 1'b1; R = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1 chk_reset();

    // Free-running fetch, then a 3-cycle stall with PC_if=8
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("c0_req", {31'b0, imem_req}, 32'd1); chk("c0_addr", imem_addr, 32'h0);
    @(negedge clk);
    #1 chk("c1_addr", imem_addr, 32'h4); chk("c1_valid", {31'b0, valid_if}, 32'd0);
    @(negedge clk);
    #1 chk("c2_valid", {31'b0, valid_if}, 32'd1); chk("c2_pc", PC_if, 32'h0);
    @(negedge clk);
    #1 chk("c3_addr", imem_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); EN = 1'b0;
      #1 chk("stall_pc", PC_if, 32'h8); chk("stall_req", {31'b0, imem_req}, 32'd0);
    end

    // Redirect while the 0x10 request is outstanding
    exp_q.push_back(32'h100);
    @(negedge clk); EN = 1'b1; mem_auto = 1'b0;
    #1 chk("unstall_req", {31'b0, imem_req}, 32'd1); chk("unstall_addr", imem_addr, 32'h10);
    @(negedge clk); R = 1'b1; redirect_pc = 32'h100;
    #1 chk("redir_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); R = 1'b0;
    #1 chk("kill_req", {31'b0, imem_req}, 32'd0); chk("kill_valid", {31'b0, valid_if}, 32'd0);
    @(negedge clk); man_rv = 1'b1; man_rd = instr_of(32'h10); mem_auto = 1'b1;
    #1 chk("stale_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); man_rv = 1'b0;
    #1 chk("redir_addr", imem_addr, 32'h100); chk("redir_req2", {31'b0, imem_req}, 32'd1);

    // Grant back-pressure for 3 cycles
    exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    @(negedge clk);
    #1 chk("c12_addr", imem_addr, 32'h104);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); gnt_on = 1'b0;
      #1 chk("bp_req", {31'b0, imem_req}, 32'd1); chk("bp_addr", imem_addr, 32'h108);
    end
    @(negedge clk); gnt_on = 1'b1;
    #1 chk("bp_release_addr", imem_addr, 32'h108);
    @(negedge clk);
    @(negedge clk);
    #1 chk("c18_pc", PC_if, 32'h108);

    // Misaligned redirect together with a stall; redirect wins
    exp_q.push_back(32'h100);
    @(negedge clk); R = 1'b1; EN = 1'b0; redirect_pc = 32'h103;
    #1 chk("prio_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); R = 1'b0; EN = 1'b1;
    #1 chk("align_addr", imem_addr, 32'h100); chk("flush_valid", {31'b0, valid_if}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("c22_pc", PC_if, 32'h100);

    // Address wrap at the top of memory
    @(negedge clk); R = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); R = 1'b0;
    #1 chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); mem_auto = 1'b0;
    #1 chk("wrap_addr", imem_addr, 32'h0); chk("wrap_req", {31'b0, imem_req}, 32'd1);

    // Reset while waiting on a response, then a late response after release
    @(negedge clk); rst_n = 1'b0; gnt_on = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_req", {31'b0, imem_req}, 32'd1); chk("rel_addr", imem_addr, 32'h0);
    @(negedge clk); man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;
    #1 chk("late_req", {31'b0, imem_req}, 32'd1); chk("late_addr", imem_addr, 32'h0);
    @(negedge clk); man_rv = 1'b0; gnt_on = 1'b1; mem_auto = 1'b1;
    #1 chk("late_valid", {31'b0, valid_if}, 32'd0);
    repeat (3) @(negedge clk);
    @(negedge clk); EN = 1'b0;
    repeat (3) @(negedge clk);
    chk("exp_left", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
